// File: rtl/regfile_dec.sv
// Register bank: write-address decoder driving per-entry flops with valid bits,
// two independent registered read ports with write-through bypass, occupancy count.

module regfile_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (we) begin
            q   <= d;
            vld <= 1'b1;
        end
    end
endmodule

module regfile_dec #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [WIDTH-1:0]      rd_data_a,
    output logic                  rd_valid_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_b,
    output logic                  rd_valid_b,
    output logic [(1<<ADDR_W)-1:0] wr_onehot,
    output logic [ADDR_W:0]       num_valid
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NPORT = 2;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic                        wr_acc;
    logic [DEPTH-1:0]            wr_dec;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            vld;
    logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
    rd_t  [NPORT-1:0]            rd_nxt;
    rd_t  [NPORT-1:0]            rd_q;

    // clr wins over a same-cycle write, so the decode is suppressed entirely
    assign wr_acc = wr_en & ~clr;
    assign wr_dec = wr_acc ? (DEPTH'(1) << wr_addr) : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        regfile_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .we    (wr_dec[i]),
            .d     (wr_data),
            .q     (mem[i]),
            .vld   (vld[i])
        );
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};

    // Bypass makes a same-cycle write visible with normal 1-cycle read latency
    always_comb begin
        rd_nxt = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (clr)
                rd_nxt[p] = '0;
            else if (wr_acc && (wr_addr == rd_addr[p]))
                rd_nxt[p] = '{valid: 1'b1, data: wr_data};
            else
                rd_nxt[p] = '{valid: vld[rd_addr[p]], data: mem[rd_addr[p]]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            wr_onehot <= '0;
            num_valid <= '0;
        end else begin
            rd_q      <= rd_nxt;
            wr_onehot <= wr_dec;
            if (clr)
                num_valid <= '0;
            else if (wr_acc && !vld[wr_addr] && (num_valid != FULL))
                num_valid <= num_valid + 1'b1;
        end
    end

    assign rd_data_a  = rd_q[0].data;
    assign rd_valid_a = rd_q[0].valid;
    assign rd_data_b  = rd_q[1].data;
    assign rd_valid_b = rd_q[1].valid;
endmodule

// File: tb/tb_regfile_dec.sv
// Directed bench for regfile_dec: reference model feeds an expectation queue,
// popped and compared after each clock edge; second instance covers WIDTH=16/ADDR_W=2.

module tb_regfile_dec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: WIDTH=8, ADDR_W=3
    logic       clr0 = 0, wr_en0 = 0;
    logic [2:0] wr_addr0 = 0, rd_addr_a0 = 0, rd_addr_b0 = 0;
    logic [7:0] wr_data0 = 0, rd_data_a0, rd_data_b0, wr_onehot0;
    logic       rd_valid_a0, rd_valid_b0;
    logic [3:0] num_valid0;

    // instance 1: WIDTH=16, ADDR_W=2
    logic        clr1 = 0, wr_en1 = 0;
    logic [1:0]  wr_addr1 = 0, rd_addr_a1 = 0, rd_addr_b1 = 0;
    logic [15:0] wr_data1 = 0, rd_data_a1, rd_data_b1;
    logic        rd_valid_a1, rd_valid_b1;
    logic [3:0]  wr_onehot1;
    logic [2:0]  num_valid1;

    regfile_dec #(.WIDTH(8), .ADDR_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0),
        .rd_valid_a(rd_valid_a0), .rd_addr_b(rd_addr_b0), .rd_data_b(rd_data_b0),
        .rd_valid_b(rd_valid_b0), .wr_onehot(wr_onehot0), .num_valid(num_valid0)
    );

    regfile_dec #(.WIDTH(16), .ADDR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
        .rd_valid_a(rd_valid_a1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1),
        .rd_valid_b(rd_valid_b1), .wr_onehot(wr_onehot1), .num_valid(num_valid1)
    );

    typedef struct {
        logic [7:0] da;
        logic       va;
        logic [7:0] db;
        logic       vb;
        logic [7:0] oh;
        logic [3:0] nv;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] m_mem[8];
    bit         m_v[8];
    int         m_nv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = '0;
            m_v[i]   = 1'b0;
        end
        m_nv = 0;
    endtask

    // Drive one cycle on instance 0, queue the model's prediction, clock, compare.
    task automatic step0(input bit c, input bit we, input int wa, input int wd,
                         input int ra, input int rb);
        exp_t e;
        logic [7:0] d8;
        d8 = wd[7:0];
        clr0 = c; wr_en0 = we; wr_addr0 = wa[2:0]; wr_data0 = d8;
        rd_addr_a0 = ra[2:0]; rd_addr_b0 = rb[2:0];
        if (c) begin
            e.da = 0; e.va = 0; e.db = 0; e.vb = 0;
        end else begin
            e.da = (we && wa == ra) ? d8 : m_mem[ra];
            e.va = (we && wa == ra) ? 1'b1 : m_v[ra];
            e.db = (we && wa == rb) ? d8 : m_mem[rb];
            e.vb = (we && wa == rb) ? 1'b1 : m_v[rb];
        end
        e.oh = (!c && we) ? (8'h01 << wa) : 8'h00;
        if (c) model_reset();
        else if (we) begin
            if (!m_v[wa] && m_nv < 8) m_nv++;
            m_mem[wa] = d8;
            m_v[wa]   = 1'b1;
        end
        e.nv = m_nv[3:0];
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("rd_data_a", 32'(rd_data_a0), 32'(e.da));
        chk("rd_valid_a", 32'(rd_valid_a0), 32'(e.va));
        chk("rd_data_b", 32'(rd_data_b0), 32'(e.db));
        chk("rd_valid_b", 32'(rd_valid_b0), 32'(e.vb));
        chk("wr_onehot", 32'(wr_onehot0), 32'(e.oh));
        chk("num_valid", 32'(num_valid0), 32'(e.nv));
        clr0 = 0; wr_en0 = 0;
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_data_a", 32'(rd_data_a0), 0);
        chk("rst_valid_a", 32'(rd_valid_a0), 0);
        chk("rst_onehot", 32'(wr_onehot0), 0);
        chk("rst_num_valid", 32'(num_valid0), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // empty bank reads back zero/invalid everywhere
        for (int i = 0; i < 8; i++) step0(0, 0, 0, 0, i, 7 - i);

        // basic write, then read on A with B on an unwritten entry
        step0(0, 1, 3, 'hA5, 0, 0);
        chk("onehot_addr3", 32'(wr_onehot0), 32'h08);
        chk("nv_after_first", 32'(num_valid0), 1);
        step0(0, 0, 0, 0, 3, 4);
        chk("read3_data", 32'(rd_data_a0), 32'hA5);
        chk("read4_valid", 32'(rd_valid_b0), 0);
        chk("onehot_pulse", 32'(wr_onehot0), 0);

        // bypass on both ports, then overwrite leaves count alone
        step0(0, 1, 5, 'h3C, 5, 5);
        chk("bypass_a", 32'(rd_data_a0), 32'h3C);
        chk("bypass_b", 32'(rd_data_b0), 32'h3C);
        step0(0, 1, 5, 'h7E, 5, 3);
        chk("overwrite_nv", 32'(num_valid0), 2);

        // fill, then rewrite a valid entry at full occupancy
        for (int i = 0; i < 8; i++) step0(0, 1, i, 'h10 + i, (i + 1) % 8, i);
        chk("full_nv", 32'(num_valid0), 8);
        step0(0, 1, 0, 'h99, 0, 7);
        chk("full_no_wrap", 32'(num_valid0), 8);
        step0(0, 0, 0, 0, 0, 6);

        // clear beats write
        step0(1, 1, 2, 'hFF, 2, 2);
        chk("clr_nv", 32'(num_valid0), 0);
        step0(0, 0, 0, 0, 2, 0);
        chk("after_clr_valid", 32'(rd_valid_a0), 0);

        // repopulate then asynchronous reset between edges
        step0(0, 1, 6, 'h5A, 6, 6);
        step0(0, 1, 1, 'h11, 6, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data_a", 32'(rd_data_a0), 0);
        chk("async_rst_valid_b", 32'(rd_valid_b0), 0);
        chk("async_rst_nv", 32'(num_valid0), 0);
        chk("async_rst_data1", 32'(rd_data_a1), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step0(0, 0, 0, 0, 6, 1);
        step0(0, 1, 4, 'hC3, 0, 4);

        // second parameter set
        wr_en1 = 1; wr_addr1 = 2; wr_data1 = 16'hBEEF; rd_addr_a1 = 2; rd_addr_b1 = 3;
        @(posedge clk); #1;
        chk("w16_bypass_a", 32'(rd_data_a1), 32'hBEEF);
        chk("w16_valid_a", 32'(rd_valid_a1), 1);
        chk("w16_valid_b", 32'(rd_valid_b1), 0);
        chk("w16_onehot", 32'(wr_onehot1), 32'h4);
        chk("w16_nv", 32'(num_valid1), 1);
        wr_addr1 = 3; wr_data1 = 16'h1234; rd_addr_a1 = 0; rd_addr_b1 = 2;
        @(posedge clk); #1;
        chk("w16_read_b", 32'(rd_data_b1), 32'hBEEF);
        chk("w16_onehot3", 32'(wr_onehot1), 32'h8);
        chk("w16_nv2", 32'(num_valid1), 2);
        wr_en1 = 0; rd_addr_a1 = 3;
        @(posedge clk); #1;
        chk("w16_read3", 32'(rd_data_a1), 32'h1234);
        chk("w16_onehot_idle", 32'(wr_onehot1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
